// File: rtl/inst_buffer_if.sv
// ============================================================================
// inst_buffer_if : fetch/dispatch packet type and buffer bus interface
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_buffer_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;
endpackage

interface inst_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  inst_buffer_pkg::IF_IB_PACKET if_ib_packet;
  logic                         flush;
  logic                         dp_ready;
  logic                         ib_full;
  logic                         ib_empty;
  inst_buffer_pkg::IF_IB_PACKET ib_dp_packet;
  logic [CNT_W-1:0]             ib_count;

  modport master (
    output if_ib_packet, flush, dp_ready,
    input  ib_full, ib_empty, ib_dp_packet, ib_count
  );

  modport slave (
    input  if_ib_packet, flush, dp_ready,
    output ib_full, ib_empty, ib_dp_packet, ib_count
  );
endinterface

`default_nettype wire

// File: rtl/inst_buffer.sv
// ============================================================================
// inst_buffer : first-word-fall-through circular instruction buffer between
//               fetch and dispatch. Optional macro: IB_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  inst_buffer_if.slave      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } ib_entry_t;

  ib_entry_t        storage_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        empty_w;
  logic        full_w;
  logic        push_en;
  logic        pop_en;
  logic        bypass_take;
  ib_entry_t   wr_entry;
  IF_IB_PACKET out_pkt;

  always_comb begin
    empty_w     = (count_q == '0);
    full_w      = (count_q == CNT_W'(DEPTH));
    bypass_take = 1'b0;
    out_pkt      = '0;
    out_pkt.inst = NOP_INST;
    wr_entry.inst = bus.if_ib_packet.inst;
    wr_entry.PC   = bus.if_ib_packet.PC;
    wr_entry.NPC  = bus.if_ib_packet.NPC;

    if (!empty_w && !bus.flush) begin
      out_pkt.valid = 1'b1;
      out_pkt.inst  = storage_q[head_q].inst;
      out_pkt.PC    = storage_q[head_q].PC;
      out_pkt.NPC   = storage_q[head_q].NPC;
    end
`ifdef IB_BYPASS_EN
    // Empty buffer: forward the fetch packet straight to dispatch.
    else if (!bus.flush && bus.if_ib_packet.valid) begin
      out_pkt       = bus.if_ib_packet;
      out_pkt.valid = 1'b1;
      bypass_take   = bus.dp_ready;
    end
`endif

    push_en = bus.if_ib_packet.valid && !full_w && !bus.flush && !bypass_take;
    pop_en  = !empty_w && !bus.flush && bus.dp_ready;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_en)  head_d = head_q + PTR_W'(1);
      if (push_en) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_en} - {{(CNT_W-1){1'b0}}, pop_en};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; every read is masked by valid.
  always_ff @(posedge clock) begin
    if (push_en) storage_q[tail_q] <= wr_entry;
  end

  assign bus.ib_full      = full_w;
  assign bus.ib_empty     = empty_w;
  assign bus.ib_count     = count_q;
  assign bus.ib_dp_packet = out_pkt;

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
// ============================================================================
// tb_inst_buffer : directed self-checking bench for inst_buffer (DEPTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;
  logic [31:0] exp_q [$];

  inst_buffer_if #(.DEPTH(DEPTH)) bus ();

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic IF_IB_PACKET mk(input logic [31:0] pc);
    IF_IB_PACKET p;
    p.valid = 1'b1;
    p.inst  = 32'hA000_0000 | pc;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.if_ib_packet = '0;
    bus.flush        = 1'b0;
    bus.dp_ready     = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    bus.dp_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.if_ib_packet = mk(base + 32'(4 * i));
      tick();
    end
    bus.if_ib_packet = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    idle_in();

    // Reset state
    repeat (3) tick();
    chk("rst_empty", 32'(bus.ib_empty), 32'd1);
    chk("rst_full",  32'(bus.ib_full),  32'd0);
    chk("rst_count", 32'(bus.ib_count), 32'd0);
    chk("rst_valid", 32'(bus.ib_dp_packet.valid), 32'd0);
    chk("rst_nop",   bus.ib_dp_packet.inst, NOP_INST);
    #3 reset_n = 1'b1;
    tick();

    // Three pushes then in-order drain
    push_n(3, 32'h0);
    chk("fifo3_count", 32'(bus.ib_count), 32'd3);
    bus.dp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fifo3_valid", 32'(bus.ib_dp_packet.valid), 32'd1);
      chk("fifo3_pc",    bus.ib_dp_packet.PC, 32'(4 * i));
      tick();
    end
    chk("fifo3_empty", 32'(bus.ib_empty), 32'd1);
    chk("fifo3_cnt0",  32'(bus.ib_count), 32'd0);
    bus.dp_ready = 1'b0;

    // Fill to full, drop the ninth push
    push_n(DEPTH, 32'h100);
    chk("full_flag",  32'(bus.ib_full),  32'd1);
    chk("full_count", 32'(bus.ib_count), 32'd8);
    bus.if_ib_packet = mk(32'h20);
    tick();
    bus.if_ib_packet = '0;
    chk("full_drop_count", 32'(bus.ib_count), 32'd8);
    bus.dp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("full_pop_pc", bus.ib_dp_packet.PC, 32'h100 + 32'(4 * i));
      tick();
    end
    chk("full_drained", 32'(bus.ib_empty), 32'd1);
    bus.dp_ready = 1'b0;

    // Sustained push+pop across pointer wrap
    push_n(3, 32'h200);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    for (int i = 0; i < 20; i++) begin
      bus.if_ib_packet = mk(32'h300 + 32'(4 * i));
      bus.dp_ready     = 1'b1;
      exp_q.push_back(32'h300 + 32'(4 * i));
      #1;
      chk("wrap_pc", bus.ib_dp_packet.PC, exp_q.pop_front());
      tick();
      chk("wrap_count", 32'(bus.ib_count), 32'd3);
    end
    bus.if_ib_packet = '0;
    while (exp_q.size() > 0) begin
      #1;
      chk("wrap_tail_pc", bus.ib_dp_packet.PC, exp_q.pop_front());
      tick();
    end
    chk("wrap_empty", 32'(bus.ib_empty), 32'd1);
    bus.dp_ready = 1'b0;

    // Flush with concurrent push and pop
    push_n(5, 32'h400);
    chk("flush_pre_count", 32'(bus.ib_count), 32'd5);
    bus.flush        = 1'b1;
    bus.if_ib_packet = mk(32'h500);
    bus.dp_ready     = 1'b1;
    #1;
    chk("flush_valid", 32'(bus.ib_dp_packet.valid), 32'd0);
    chk("flush_nop",   bus.ib_dp_packet.inst, NOP_INST);
    tick();
    idle_in();
    #1;
    chk("flush_count", 32'(bus.ib_count), 32'd0);
    chk("flush_empty", 32'(bus.ib_empty), 32'd1);
    chk("flush_after_valid", 32'(bus.ib_dp_packet.valid), 32'd0);

    // Asynchronous reset with 4 entries buffered
    push_n(4, 32'h600);
    chk("arst_pre_count", 32'(bus.ib_count), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.ib_empty), 32'd1);
    chk("arst_count", 32'(bus.ib_count), 32'd0);
    chk("arst_valid", 32'(bus.ib_dp_packet.valid), 32'd0);
    tick();
    #3 reset_n = 1'b1;
    tick();
    bus.if_ib_packet = mk(32'h700);
    tick();
    bus.if_ib_packet = '0;
    chk("arst_resume_valid", 32'(bus.ib_dp_packet.valid), 32'd1);
    chk("arst_resume_pc",    bus.ib_dp_packet.PC, 32'h700);
    bus.dp_ready = 1'b1;
    tick();
    chk("arst_resume_empty", 32'(bus.ib_empty), 32'd1);

    // Push into empty buffer with dispatch ready
    bus.if_ib_packet = mk(32'h40);
    bus.dp_ready     = 1'b1;
    #1;
`ifdef IB_BYPASS_EN
    chk("byp_valid", 32'(bus.ib_dp_packet.valid), 32'd1);
    chk("byp_pc",    bus.ib_dp_packet.PC, 32'h40);
    tick();
    bus.if_ib_packet = '0;
    #1;
    chk("byp_count", 32'(bus.ib_count), 32'd0);
    chk("byp_empty", 32'(bus.ib_empty), 32'd1);
`else
    chk("lat_valid0", 32'(bus.ib_dp_packet.valid), 32'd0);
    tick();
    bus.if_ib_packet = '0;
    #1;
    chk("lat_valid1", 32'(bus.ib_dp_packet.valid), 32'd1);
    chk("lat_pc",     bus.ib_dp_packet.PC, 32'h40);
    chk("lat_count",  32'(bus.ib_count), 32'd1);
    tick();
    chk("lat_drained", 32'(bus.ib_count), 32'd0);
`endif
    idle_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning buffer entries; power of two, 2..32.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_ib_packet  input  IF_IB_PACKET  fetch packet; .valid marks a push request.
REQ-005 SHALL have port flush  input  1  squash all buffered and incoming instructions.
REQ-006 SHALL have port dp_ready  input  1  dispatch accepts the head entry this cycle.
REQ-007 SHALL have port ib_full  output  1  no free entry; fetch must not push.
REQ-008 SHALL have port ib_empty  output  1  zero occupancy.
REQ-009 SHALL have port ib_dp_packet  output  IF_IB_PACKET  head entry; .valid means ib_dp_packet is valid.
REQ-010 SHALL have port ib_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL be a circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-012 SHALL perform a push on a rising edge when if_ib_packet.valid=1, ib_full=0 and flush=0, writing inst/PC/NPC at tail and incrementing tail.
REQ-013 SHALL perform a pop on a rising edge when ib_dp_packet.valid=1, dp_ready=1 and flush=0, incrementing head.
REQ-014 SHALL present the head entry first-word-fall-through: ib_dp_packet reflects storage[head] combinationally, .valid = !ib_empty && !flush.
REQ-015 SHALL drive ib_dp_packet to all-zero with inst=NOP whenever .valid=0.
REQ-016 SHALL drive ib_full = (ib_count==DEPTH) and ib_empty = (ib_count==0), both from registered state only (no combinational path from any input).
REQ-017 SHALL, on simultaneous push and pop, keep ib_count unchanged and advance both pointers.
REQ-018 SHALL ignore a push while full even if a pop occurs in the same cycle (packet dropped; fetch holds PC via ib_full).
REQ-019 SHALL ignore a pop request while empty (no pointer change).
REQ-020 SHALL, on flush=1, reset head, tail and ib_count to 0 at the next edge, discarding any same-cycle push and pop.
REQ-021 SHALL have minimum push-to-dispatch latency of one cycle (entry visible the cycle after the push edge).
REQ-022 SHALL keep ib_count in 0..DEPTH at all times; ib_count = pushes - pops since last reset/flush.

Reset
REQ-023 SHALL, on reset_n=0, immediately clear head, tail, ib_count to 0, giving ib_empty=1, ib_full=0, ib_dp_packet.valid=0 without waiting for a clock edge.
REQ-024 SHALL not require storage array contents to be reset; outputs SHALL be masked by .valid.
REQ-025 SHALL, on reset asserted mid-operation, lose all entries and resume accepting pushes the first edge after reset_n rises.

Configuration
REQ-026 SHALL support macro IB_BYPASS_EN: when defined, if ib_empty=1, flush=0 and if_ib_packet.valid=1, ib_dp_packet SHALL be the incoming packet combinationally; if dp_ready=1 the packet is consumed without being written and counters are unchanged; otherwise it is written normally.
REQ-027 SHALL, without IB_BYPASS_EN, never pass the input to the output combinationally (latency per REQ-021).

Verification
REQ-028 SHALL pass: reset, push PC=0x0,0x4,0x8 with dp_ready=0 -> ib_count=3; then dp_ready=1 -> PCs emerge 0x0,0x4,0x8 on consecutive cycles, ib_empty=1 after.
REQ-029 SHALL pass: DEPTH=8, push 8 with dp_ready=0 -> ib_full=1, ib_count=8; 9th push (PC=0x20) ignored; after 8 pops none reads PC=0x20.
REQ-030 SHALL pass: continuous push+pop for 20 cycles at DEPTH=8 -> pointers wrap twice, ib_count constant, output order equals input order.
REQ-031 SHALL pass: 5 entries buffered, flush=1 with push and dp_ready=1 -> ib_dp_packet.valid=0 that cycle, ib_count=0 next cycle, no entry emerges.
REQ-032 SHALL pass: reset_n dropped mid-cycle with 4 entries -> ib_empty=1 before next clock edge; push after release emerges normally.
REQ-033 SHALL pass with IB_BYPASS_EN: empty buffer, push PC=0x40 with dp_ready=1 -> ib_dp_packet.PC=0x40 valid same cycle, ib_count stays 0; without macro -> appears one cycle later.
